// File: rtl/issue_buffer.sv
// issue_buffer: circular instruction queue between decode and issue.
// Accepts up to two decoded instructions per cycle and presents the oldest
// one or two entries to issue in program order. Pairs only when the pair has
// no RAW/WAW hazard and at most one non-ALU instruction.
module issue_buffer #(
    parameter int          DEPTH    = 8,
    parameter int          W        = 128,
    parameter logic [9:0]  ALU_TYPE = 10'h001
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       stall,
    input  logic                       in_valid1,
    input  logic                       in_valid2,
    input  logic [W-1:0]               in_data1,
    input  logic [W-1:0]               in_data2,
    input  logic [9:0]                 in_type1,
    input  logic [9:0]                 in_type2,
    input  logic                       in_we1,
    input  logic                       in_we2,
    input  logic [4:0]                 in_rd1,
    input  logic [4:0]                 in_rd2,
    input  logic [4:0]                 in_ra1_1,
    input  logic [4:0]                 in_ra2_1,
    input  logic [4:0]                 in_ra1_2,
    input  logic [4:0]                 in_ra2_2,
    output logic                       in_ready,
    output logic                       o_valid1,
    output logic                       o_valid2,
    output logic [W-1:0]               o_data1,
    output logic [W-1:0]               o_data2,
    output logic [9:0]                 o_type1,
    output logic [9:0]                 o_type2,
    output logic                       o_we1,
    output logic                       o_we2,
    output logic [4:0]                 o_rd1,
    output logic [4:0]                 o_rd2,
    output logic [4:0]                 o_ra1_1,
    output logic [4:0]                 o_ra2_1,
    output logic [4:0]                 o_ra1_2,
    output logic [4:0]                 o_ra2_2,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [W-1:0] data;
        logic [9:0]   typ;
        logic         we;
        logic [4:0]   rd;
        logic [4:0]   ra1;
        logic [4:0]   ra2;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    entry_t          in1, in2, e1, e2, s1, s2;
    logic            pair_ok;
    logic [1:0]      enq, deq;

    assign in1 = '{data: in_data1, typ: in_type1, we: in_we1, rd: in_rd1,
                   ra1: in_ra1_1, ra2: in_ra2_1};
    assign in2 = '{data: in_data2, typ: in_type2, we: in_we2, rd: in_rd2,
                   ra1: in_ra1_2, ra2: in_ra2_2};

    // Head pair decode, pairing rules and enqueue/dequeue amounts
    always_comb begin
        e1       = mem_q[head_q];
        e2       = mem_q[head_q + PW'(1)];
        in_ready = count_q <= CW'(DEPTH - 2);
        pair_ok  = 1'b1;
        if (e1.typ != ALU_TYPE && e2.typ != ALU_TYPE)
            pair_ok = 1'b0;
        if (e1.we && e1.rd != 5'd0 && (e1.rd == e2.ra1 || e1.rd == e2.ra2))
            pair_ok = 1'b0;
        if (e1.we && e2.we && e1.rd != 5'd0 && e1.rd == e2.rd)
            pair_ok = 1'b0;
        o_valid1 = count_q != '0;
        o_valid2 = (count_q >= CW'(2)) && pair_ok;
        s1       = o_valid1 ? e1 : '0;
        s2       = o_valid2 ? e2 : '0;
        enq      = (flush || !in_ready || !in_valid1) ? 2'd0 :
                   (in_valid2 ? 2'd2 : 2'd1);
        deq      = (stall || flush) ? 2'd0 :
                   ({1'b0, o_valid1} + {1'b0, o_valid2});
        head_d   = head_q + PW'(deq);
        tail_d   = tail_q + PW'(enq);
        count_d  = count_q + CW'(enq) - CW'(deq);
    end

    assign o_data1  = s1.data;
    assign o_type1  = s1.typ;
    assign o_we1    = s1.we;
    assign o_rd1    = s1.rd;
    assign o_ra1_1  = s1.ra1;
    assign o_ra2_1  = s1.ra2;
    assign o_data2  = s2.data;
    assign o_type2  = s2.typ;
    assign o_we2    = s2.we;
    assign o_rd2    = s2.rd;
    assign o_ra1_2  = s2.ra1;
    assign o_ra2_2  = s2.ra2;
    assign o_count  = count_q;

    // Pointer and occupancy registers; flush empties the queue
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage, unreset; slot 2 lands right behind slot 1
    always_ff @(posedge clk) begin
        if (enq != 2'd0)
            mem_q[tail_q] <= in1;
        if (enq == 2'd2)
            mem_q[tail_q + PW'(1)] <= in2;
    end

    a_count_max: assert property (@(posedge clk) disable iff (rst)
        count_q <= CW'(DEPTH));
    a_no_ovf:    assert property (@(posedge clk) disable iff (rst)
        !in_ready |-> enq == 2'd0);
    a_v2_v1:     assert property (@(posedge clk) disable iff (rst)
        o_valid2 |-> o_valid1);

endmodule
